// File: rtl/joy_pkg.sv
// joy_pkg: bit map and widths shared by the joystick conditioner
package joy_pkg;
    localparam int JOY_W  = 10;
    localparam int NBTN   = 6;
    localparam int JOY_R  = 0;
    localparam int JOY_L  = 1;
    localparam int JOY_D  = 2;
    localparam int JOY_U  = 3;
    localparam int JOY_K1 = 4;
    localparam int JOY_K2 = 5;
    localparam int JOY_K3 = 6;
    localparam int JOY_K4 = 7;
    localparam int JOY_K5 = 8;
    localparam int JOY_K6 = 9;
endpackage

// File: rtl/joy_debounce.sv
// joy_debounce: accepts a new level after DEB_TICKS consecutive mismatching ticks
module joy_debounce #(
    parameter int DEB_TICKS = 4
) (
    input  logic clk_sys,
    input  logic reset_n,
    input  logic sync,
    input  logic tick,
    output logic db
);
    localparam int CW = $clog2(DEB_TICKS + 1);
    logic [CW-1:0] cnt;
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            db  <= 1'b0;
            cnt <= '0;
        end else if (sync == db) begin
            cnt <= '0;
        end else if (tick) begin
            if (cnt == CW'(DEB_TICKS - 1)) begin
                db  <= sync;
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

// File: rtl/joy_cond.sv
// joy_cond: synchronise, debounce, resolve opposing directions and autofire a raw joystick word
module joy_cond
    import joy_pkg::*;
#(
    parameter int TICK_DIV  = 3579,
    parameter int DEB_TICKS = 4,
    parameter int AF_TICKS  = 33
) (
    input  logic             clk_sys,
    input  logic             reset_n,
    input  logic [JOY_W-1:0] joy_raw,
    input  logic [NBTN-1:0]  af_en,
    output logic [JOY_W-1:0] joy_out,
    output logic             joy_chg
);
    localparam int PW = $clog2(TICK_DIV);
    localparam int AW = $clog2(AF_TICKS + 1);
    logic [JOY_W-1:0] sync1, sync2, db, nxt;
    logic [PW-1:0]    pcnt;
    logic [AW-1:0]    af_cnt;
    logic             af_phase, tick, hold;
    logic [3:0]       dir;
    logic [NBTN-1:0]  btn;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= joy_raw;
            sync2 <= sync1;
        end
    end

    assign tick = pcnt == PW'(TICK_DIV - 1);

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) pcnt <= '0;
        else          pcnt <= tick ? '0 : pcnt + 1'b1;
    end

    for (genvar i = 0; i < JOY_W; i++) begin : g_deb
        joy_debounce #(.DEB_TICKS(DEB_TICKS)) u_deb (
            .clk_sys (clk_sys),
            .reset_n (reset_n),
            .sync    (sync2[i]),
            .tick    (tick),
            .db      (db[i])
        );
    end

    // all autofire buttons share one phase; it parks at 1 so a fresh press fires at once
    assign hold = |(af_en & db[JOY_K6:JOY_K1]);

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            af_cnt   <= '0;
            af_phase <= 1'b1;
        end else if (!hold) begin
            af_cnt   <= '0;
            af_phase <= 1'b1;
        end else if (tick) begin
            af_cnt   <= (af_cnt == AW'(AF_TICKS - 1)) ? '0 : af_cnt + 1'b1;
            af_phase <= (af_cnt == AW'(AF_TICKS - 1)) ? ~af_phase : af_phase;
        end
    end

    always_comb begin
        dir[JOY_R] = db[JOY_R] & ~db[JOY_L];
        dir[JOY_L] = db[JOY_L] & ~db[JOY_R];
        dir[JOY_D] = db[JOY_D] & ~db[JOY_U];
        dir[JOY_U] = db[JOY_U] & ~db[JOY_D];
        btn        = db[JOY_K6:JOY_K1] & (~af_en | {NBTN{af_phase}});
        nxt        = {btn, dir};
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            joy_out <= '0;
            joy_chg <= 1'b0;
        end else begin
            joy_out <= nxt;
            joy_chg <= nxt != joy_out;
        end
    end
endmodule

// File: tb/tb_joy_cond.sv
// tb_joy_cond: directed and random stimulus checked against a tick-counting reference model
module tb_joy_cond;
    localparam int TD  = 4;
    localparam int DEB = 3;
    localparam int AF  = 2;

    logic       clk_sys, reset_n, run, joy_chg;
    logic [9:0] joy_raw, joy_out;
    logic [5:0] af_en;
    int         checks, errors, chg_cnt;

    logic [9:0] s1, s2, m_db, m_out;
    logic       m_chg;
    int         mis[10];
    int         cyc, held;

    joy_cond #(.TICK_DIV(TD), .DEB_TICKS(DEB), .AF_TICKS(AF)) dut (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .joy_raw (joy_raw),
        .af_en   (af_en),
        .joy_out (joy_out),
        .joy_chg (joy_chg)
    );

    initial begin
        clk_sys = 1'b0;
        forever begin
            #5;
            if (run) clk_sys = ~clk_sys;
        end
    end

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic m_reset();
        s1 = '0; s2 = '0; m_db = '0; m_out = '0; m_chg = 1'b0;
        cyc = 0; held = 0;
        for (int i = 0; i < 10; i++) mis[i] = 0;
    endtask

    // model: tick from elapsed cycles, debounce as a count of mismatching ticks,
    // autofire phase from the number of ticks the hold has lasted
    task automatic m_edge();
        logic [9:0] nx;
        logic       tk, ph, hd;
        tk = (cyc % TD) == TD - 1;
        ph = ((held / AF) % 2) == 0;
        hd = |(af_en & m_db[9:4]);
        nx[0] = m_db[0] && !m_db[1];
        nx[1] = m_db[1] && !m_db[0];
        nx[2] = m_db[2] && !m_db[3];
        nx[3] = m_db[3] && !m_db[2];
        for (int k = 0; k < 6; k++) nx[4+k] = m_db[4+k] && (!af_en[k] || ph);
        m_chg = nx != m_out;
        m_out = nx;
        for (int i = 0; i < 10; i++) begin
            if (s2[i] == m_db[i]) mis[i] = 0;
            else if (tk) begin
                mis[i]++;
                if (mis[i] == DEB) begin
                    m_db[i] = s2[i];
                    mis[i] = 0;
                end
            end
        end
        held = !hd ? 0 : (tk ? held + 1 : held);
        s2 = s1;
        s1 = joy_raw;
        cyc++;
    endtask

    task automatic step();
        @(posedge clk_sys);
        m_edge();
        #1;
        chk("out", {6'd0, joy_out}, {6'd0, m_out});
        chk("chg", {15'd0, joy_chg}, {15'd0, m_chg});
        if (joy_chg) chg_cnt++;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wait_bit(input int b, input logic v, input int lim, output int n);
        n = 0;
        while (joy_out[b] !== v && n < lim) begin
            step();
            n++;
        end
    endtask

    initial begin
        int n, c0;
        checks = 0; errors = 0; chg_cnt = 0;
        run = 1'b0; reset_n = 1'b0; joy_raw = 10'h3FF; af_en = '0;
        m_reset();
        #1;
        chk("rst_out", {6'd0, joy_out}, 16'h0);
        chk("rst_chg", {15'd0, joy_chg}, 16'h0);
        joy_raw = '0;
        #2 reset_n = 1'b1;
        #2 run = 1'b1;
        c0 = chg_cnt;
        steps(50);
        chk("idle_out", {6'd0, joy_out}, 16'h0);
        chk("idle_chg", 16'(chg_cnt - c0), 16'h0);

        joy_raw[4] = 1'b1;
        c0 = chg_cnt;
        wait_bit(4, 1'b1, 40, n);
        chk("press_lat", {15'd0, (n >= 12 && n <= 16)}, 16'h1);
        steps(8);
        chk("press_chg", 16'(chg_cnt - c0), 16'h1);
        joy_raw[4] = 1'b0;
        c0 = chg_cnt;
        wait_bit(4, 1'b0, 40, n);
        chk("rel_lat", {15'd0, (n >= 12 && n <= 16)}, 16'h1);
        steps(8);
        chk("rel_chg", 16'(chg_cnt - c0), 16'h1);

        c0 = chg_cnt;
        joy_raw[0] = 1'b1;
        steps(8);
        joy_raw[0] = 1'b0;
        steps(20);
        chk("glitch_out", {6'd0, joy_out}, 16'h0);
        chk("glitch_chg", 16'(chg_cnt - c0), 16'h0);

        joy_raw = 10'h001; steps(20);
        chk("opp_r", {6'd0, joy_out}, 16'h001);
        joy_raw = 10'h003; steps(20);
        chk("opp_rl", {14'd0, joy_out[1:0]}, 16'h0);
        joy_raw = 10'h002; steps(20);
        chk("opp_l", {14'd0, joy_out[1:0]}, 16'h2);
        joy_raw = 10'h004; steps(20);
        chk("opp_d", {6'd0, joy_out}, 16'h004);
        joy_raw = 10'h00C; steps(20);
        chk("opp_du", {14'd0, joy_out[3:2]}, 16'h0);
        joy_raw = 10'h008; steps(20);
        chk("opp_u", {14'd0, joy_out[3:2]}, 16'h2);
        joy_raw = 10'h000; steps(20);

        af_en = 6'b000001;
        joy_raw = 10'h030;
        wait_bit(4, 1'b1, 40, n);
        chk("af_acc", {6'd0, joy_out}, 16'h030);
        wait_bit(4, 1'b0, 20, n);
        chk("af_k2", {15'd0, joy_out[5]}, 16'h1);
        wait_bit(4, 1'b1, 20, n);
        chk("af_low", 16'(n), 16'd8);
        wait_bit(4, 1'b0, 20, n);
        chk("af_high", 16'(n), 16'd8);
        joy_raw = 10'h020; steps(30);
        chk("af_rel", {6'd0, joy_out}, 16'h020);
        joy_raw = 10'h030;
        wait_bit(4, 1'b1, 40, n);
        chk("af_restart", {15'd0, joy_out[4]}, 16'h1);
        steps(20);

        joy_raw = 10'h010;
        reset_n = 1'b0;
        #2;
        chk("mid_rst_out", {6'd0, joy_out}, 16'h0);
        chk("mid_rst_chg", {15'd0, joy_chg}, 16'h0);
        m_reset();
        repeat (2) @(posedge clk_sys);
        #1 reset_n = 1'b1;
        wait_bit(4, 1'b1, 40, n);
        chk("mid_rst_lat", {15'd0, (n >= 12 && n <= 16)}, 16'h1);
        steps(20);

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 15) == 0) joy_raw[$urandom_range(0, 9)] ^= 1'b1;
            if ($urandom_range(0, 199) == 0) af_en = 6'($urandom);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/joy_cond.md
Name: joy_cond

Overview:
Upstream conditioner for the hand-controller encoder. It takes the raw 10-bit MiSTer joystick word and produces a cleaned 10-bit word that feeds the pad encoder's joy_in. The cleaned word is synchronised, debounced per bit, free of opposing directions, and optionally autofired per button. One instance is used per controller.

Parameters:
TICK_DIV, 3579, clk_sys cycles per sample tick (about 1 kHz at 3.58 MHz); must be >=2
DEB_TICKS, 4, consecutive mismatching ticks needed to accept a new bit level; must be >=1
AF_TICKS, 33, ticks per autofire half-period

Ports:
clk_sys  in  1  system clock; single clock domain
reset_n  in  1  asynchronous, active-low reset
joy_raw  in  10  raw joystick, active-high: [0]=R [1]=L [2]=D [3]=U [9:4]=buttons K1..K6
af_en  in  6  per-button autofire enable; af_en[k] applies to joy bit k+4; sampled every cycle
joy_out  out  10  conditioned joystick, same bit map, registered
joy_chg  out  1  one-cycle pulse when joy_out changed on the previous edge

Behaviour:
- Reset: reset_n low asynchronously clears all state; joy_out=0, joy_chg=0, sync FFs=0, counters=0, af_phase=1. A reset mid-debounce or mid-autofire discards the pending state; there is no recovery of the earlier level.
- Synchroniser: 2-FF on every joy_raw bit, giving sync[9:0] with 2 cycles of latency.
- Prescaler: counter 0..TICK_DIV-1. tick=1 for one cycle when the counter equals TICK_DIV-1, then it wraps to 0. The counter free-runs from reset.
- Debounce, per bit i, with stable level db[i] and counter cnt[i] of width clog2(DEB_TICKS+1):
  - If sync[i]==db[i]: cnt[i]<=0, on any cycle.
  - Else on tick: if cnt[i]==DEB_TICKS-1 then db[i]<=sync[i] and cnt[i]<=0; otherwise cnt[i]++.
  - Else (mismatch, no tick): hold.
  - A mismatch that disappears before acceptance leaves db unchanged.
- Opposing directions, on debounced values:
  - db[0]&db[1] forces both R and L to 0.
  - db[2]&db[3] forces both D and U to 0.
  - Releasing one side restores the other on the next cycle.
- Autofire:
  - hold = |(af_en & db[9:4]).
  - While hold=0: af_cnt<=0, af_phase<=1.
  - While hold=1, on tick: af_cnt++; at AF_TICKS-1 it wraps to 0 and af_phase toggles.
  - Button k is output as db[k+4] & (af_en[k] ? af_phase : 1).
  - The first press therefore fires immediately. All autofire buttons share the phase.
- Output:
  - next = {buttons, directions}; joy_out<=next every cycle.
  - joy_chg<=(next!=joy_out).
  - The output register adds 1 cycle of latency after db.
- Total latency from a raw edge to joy_out: 2 sync cycles + DEB_TICKS ticks (partial first tick) + 1 cycle.
- Width rules: all counters saturate only by wrap as described; no arithmetic on joystick bits.

Decomposition:
- Package joy_pkg: bit-index constants JOY_R=0, JOY_L=1, JOY_D=2, JOY_U=3, JOY_K1=4..JOY_K6=9; JOY_W=10; NBTN=6.
- Sub-module joy_debounce (one bit: sync level in, tick in, db out, parameter DEB_TICKS), instantiated JOY_W times via generate.
- Prescaler, opposing-direction logic, autofire and the output register live in joy_cond.

Test Plan:
Bench parameters: TICK_DIV=4, DEB_TICKS=3, AF_TICKS=2.
1. Reset: hold reset_n=0 with the clock stopped and joy_raw=3FF -> joy_out=000 and joy_chg=0 immediately. Release reset with joy_raw=000 -> outputs stay 0 for 50 cycles.
2. Clean press: joy_raw[4] 0->1 and held -> joy_out[4] rises between 12 and 16 cycles after the edge; joy_chg pulses exactly once. Release -> joy_out[4] falls within the same window; joy_chg pulses once.
3. Glitch rejection: joy_raw[0] high for 8 cycles (2 ticks) then low -> joy_out stays 000 and joy_chg never asserts.
4. Opposing directions: R debounced high (joy_out=001), then L added -> joy_out[1:0]=00. Drop R -> joy_out[1:0]=10. The same check applies to U+D on bits [3:2].
5. Autofire: af_en=000001, hold joy_raw[4] -> joy_out[4]=1 at acceptance, then toggles every 8 cycles (0 for 8, 1 for 8, ...). joy_raw[5] held with af_en[1]=0 stays a steady 1. Release bit 4 -> phase restarts at 1 on the next press.
6. Reset mid-operation: assert reset_n=0 during autofire while joy_raw=010 -> joy_out=000 asynchronously. After release, the full debounce latency applies again before joy_out[4]=1.
